// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, code width and execution FSM state encodings.
// Imported by the execution unit and its decode logic so the encodings live in one place.
package alu_pkg;

   localparam int ALU_CTRL_W = 3;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b011;
   localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   function automatic logic is_mul(input logic [ALU_CTRL_W-1:0] code);
      return code == ALU_MUL;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier returning the low word of the product.
// One iteration per cycle after start; done flags the cycle carrying the final iteration.
module alu_mul_iter #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   logic             running;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;

   assign acc_next = acc + (mplier[0] ? mcand : '0);

   // product exposes the accumulator after the current iteration so the
   // owner can register it on the same edge that ends the multiply
   assign product = acc_next;
   assign done    = running && (cnt == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         running <= 1'b0;
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= CW'(MUL_CYCLES - 1);
         mcand   <= op_a;
         mplier  <= op_b;
         acc     <= '0;
      end else if (running) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (cnt == '0) begin
            running <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle and/or/add/sub, iterative multiply, registered result.
// busy_o doubles as the pipeline stall request while a multiply is running.
//
// state   | meaning
// IDLE    | waiting for a request, ready_o high
// MUL     | multiply iterating, requests ignored, busy_o high
// DONE    | result presented for one cycle, accepts a new request like IDLE
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic [ALU_CTRL_W-1:0] ALUCtrl_i,
   input  logic [WIDTH-1:0]      data1_i,
   input  logic [WIDTH-1:0]      data2_i,
   output logic                  ready_o,
   output logic                  valid_o,
   output logic [WIDTH-1:0]      data_o,
   output logic                  zero_o,
   output logic                  busy_o
);

   alu_state_e       state;
   logic             accept;
   logic             start_mul;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] alu_res;

   assign accept    = valid_i && ready_o;
   assign start_mul = accept && is_mul(ALUCtrl_i);

   // Undefined codes (and mul, which is handled by the iterator) decode to zero
   always_comb begin
      alu_res = '0;
      case (ALUCtrl_i)
         ALU_AND: alu_res = data1_i & data2_i;
         ALU_OR:  alu_res = data1_i | data2_i;
         ALU_ADD: alu_res = data1_i + data2_i;
         ALU_SUB: alu_res = data1_i - data2_i;
         default: alu_res = '0;
      endcase
   end

   alu_mul_iter #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start   (start_mul),
      .op_a    (data1_i),
      .op_b    (data2_i),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         ready_o <= 1'b1;
         valid_o <= 1'b0;
         busy_o  <= 1'b0;
         data_o  <= '0;
         zero_o  <= 1'b1;
      end else begin
         valid_o <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (is_mul(ALUCtrl_i)) begin
                     state   <= ST_MUL;
                     ready_o <= 1'b0;
                     busy_o  <= 1'b1;
                  end else begin
                     state   <= ST_DONE;
                     valid_o <= 1'b1;
                     data_o  <= alu_res;
                     zero_o  <= (alu_res == '0);
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  state   <= ST_DONE;
                  ready_o <= 1'b1;
                  busy_o  <= 1'b0;
                  valid_o <= 1'b1;
                  data_o  <= mul_product;
                  zero_o  <= (mul_product == '0);
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_o <= 1'b1;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         valid_i;
   logic [2:0]   ALUCtrl_i;
   logic [W-1:0] data1_i;
   logic [W-1:0] data2_i;
   logic         ready_o;
   logic         valid_o;
   logic [W-1:0] data_o;
   logic         zero_o;
   logic         busy_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   alu_exec_unit #(.WIDTH(W), .MUL_CYCLES(W)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ALUCtrl_i (ALUCtrl_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .ready_o   (ready_o),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .zero_o    (zero_o),
      .busy_o    (busy_o)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [2*W-1:0] p;
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a + b;
         3'd3: return a - b;
         3'd4: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return p[W-1:0];
         end
         default: return '0;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge of the result cycle with valid_i low.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noise);
      int           lat;
      logic [W-1:0] exp;
      lat = (op == 3'd4) ? W + 1 : 1;
      exp = model(op, a, b);
      check("ready_before_req", ready_o, 1);
      valid_i   = 1'b1;
      ALUCtrl_i = op;
      data1_i   = a;
      data2_i   = b;
      @(posedge clk_i);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk_i);
         check("valid_o_timing", valid_o, (k == lat));
         check("busy_o_timing", busy_o, (k < lat));
         check("ready_o_timing", ready_o, (k == lat));
         if (k == lat) begin
            check("data_o", data_o, exp);
            check("zero_o", zero_o, (exp == '0));
         end
         if (noise && k < lat) begin
            valid_i   = 1'b1;
            ALUCtrl_i = 3'($urandom_range(0, 7));
            data1_i   = $urandom;
            data2_i   = $urandom;
         end else begin
            valid_i = 1'b0;
         end
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk_i);
      check("valid_o_single_pulse", valid_o, 0);
      check("ready_o_idle", ready_o, 1);
      check("busy_o_idle", busy_o, 0);
   endtask

   task automatic mul_abort(input bit follow_with_or);
      valid_i   = 1'b1;
      ALUCtrl_i = 3'd4;
      data1_i   = $urandom | 32'h1;
      data2_i   = $urandom | 32'h1;
      @(posedge clk_i);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk_i);
         valid_i = 1'b0;
         check("abort_busy_before_rst", busy_o, 1);
      end
      rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      check("abort_ready", ready_o, 1);
      check("abort_valid", valid_o, 0);
      check("abort_busy", busy_o, 0);
      check("abort_data", data_o, 0);
      check("abort_zero", zero_o, 1);
      if (follow_with_or) begin
         issue(3'd1, 32'd1, 32'd2, 1'b0);
         check("or_after_reset", data_o, 32'd3);
         idle_cycle();
      end else begin
         for (int k = 0; k < W + 8; k++) begin
            @(negedge clk_i);
            check("abort_no_valid", valid_o, 0);
         end
      end
   endtask

   initial begin
      logic [2:0] op;
      rst_i     = 1'b1;
      valid_i   = 1'b0;
      ALUCtrl_i = '0;
      data1_i   = '0;
      data2_i   = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_ready", ready_o, 1);
      check("rst_valid", valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_data", data_o, 0);
      check("rst_zero", zero_o, 1);
      rst_i = 1'b0;

      // request in the very first cycle after reset release
      issue(3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      idle_cycle();
      issue(3'd3, 32'd5, 32'd5, 1'b0);
      issue(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
      check("and_back_to_back", data_o, 32'hF000_F000);
      idle_cycle();
      issue(3'd4, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
      check("mul_neg", data_o, 32'hFFFF_FFFD);
      idle_cycle();
      issue(3'd4, 32'd12345, 32'd6789, 1'b1);
      check("mul_noise", data_o, 32'd83810205);
      idle_cycle();
      issue(3'b110, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      idle_cycle();
      issue(3'd4, 32'd0, 32'hFFFF_FFFF, 1'b0);
      idle_cycle();

      mul_abort(1'b1);
      mul_abort(1'b0);

      for (int i = 0; i < 150; i++) begin
         op = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       issue(op, $urandom, 32'd0, bit'($urandom_range(0, 1)));
            1:       issue(op, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), 1'b0);
            default: issue(op, $urandom, $urandom, bit'($urandom_range(0, 1)));
         endcase
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits.
REQ-002 Parameter MUL_CYCLES, default WIDTH, number of multiply iterations; it SHALL equal WIDTH.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  operation request.
REQ-006 ALUCtrl_i  input  3  operation code: 000 and, 001 or, 010 add, 011 sub, 100 mul, 101-111 undefined.
REQ-007 data1_i  input  WIDTH  operand A.
REQ-008 data2_i  input  WIDTH  operand B.
REQ-009 ready_o  output  1  unit can accept a request this cycle.
REQ-010 valid_o  output  1  one-cycle pulse; data_o holds a new result.
REQ-011 data_o  output  WIDTH  result, held until the next result.
REQ-012 zero_o  output  1  high when data_o equals zero; registered with data_o.
REQ-013 busy_o  output  1  multiply in progress; serves as the pipeline stall request.

Function
REQ-014 A request SHALL be accepted in any cycle where valid_i and ready_o are both high; operands and code SHALL be captured in that cycle.
REQ-015 valid_i while ready_o is low SHALL be ignored, with no capture and no side effect.
REQ-016 The FSM SHALL have states IDLE, MUL and DONE.
REQ-017 ready_o SHALL be high in IDLE and DONE and low in MUL.
REQ-018 busy_o SHALL be high exactly in MUL.
REQ-019 Codes 000-011 accepted in cycle N SHALL produce valid_o in cycle N+1, with the FSM going to DONE.
REQ-020 Code 100 accepted in cycle N SHALL enter MUL and perform one shift-add iteration per cycle, for MUL_CYCLES cycles (N+1..N+32).
REQ-021 After the multiply iterations, the FSM SHALL go to DONE and assert valid_o in cycle N+33.
REQ-022 DONE SHALL last one cycle; it SHALL return to IDLE, or act as IDLE if a new request is accepted in it (back-to-back throughput).
REQ-023 and/or SHALL be bitwise.
REQ-024 add/sub SHALL be modulo 2^WIDTH with no overflow flag.
REQ-025 mul SHALL return the low WIDTH bits of the product, identical for signed and unsigned operands.
REQ-026 Undefined codes SHALL be accepted with 1-cycle latency, returning data_o=0 and zero_o=1.
REQ-027 The multiply iteration counter SHALL count from MUL_CYCLES-1 down to 0; the iteration at 0 SHALL be the last; the counter SHALL never wrap.
REQ-028 Input changes during MUL SHALL NOT affect the result in progress.
REQ-029 valid_o SHALL never be high for two consecutive cycles from one request.

Reset
REQ-030 While rst_i is high at a clock edge: FSM IDLE, ready_o=1, valid_o=0, busy_o=0, data_o=0, zero_o=1, counter=0.
REQ-031 Reset SHALL take priority over acceptance.
REQ-032 Reset during MUL SHALL abort the multiply with no valid_o; the result SHALL be discarded.
REQ-033 A request SHALL be acceptable in the first cycle after rst_i is deasserted.

Structure
REQ-034 A shared package alu_pkg SHALL hold: the ALUCtrl code constants (AND, OR, ADD, SUB, MUL), the ALUCtrl width (3) and the FSM state encodings; both decoder and unit SHALL use it.
REQ-035 The iterative multiplier SHALL be one sub-module, alu_mul_iter (start, operands, done, product low word), driven by the FSM.
REQ-036 All outputs SHALL be registered; the logic from inputs to outputs SHALL NOT be combinational.

Verification
REQ-037 add 0x7FFFFFFF + 0x00000001 accepted in cycle N -> valid_o in N+1, data_o=0x80000000, zero_o=0.
REQ-038 sub 5 - 5 -> data_o=0, zero_o=1 in N+1; a following and 0xF0F0F0F0 & 0xFF00FF00 accepted in DONE -> 0xF000F000 one cycle later.
REQ-039 mul 0xFFFFFFFF * 0x00000003 accepted in N -> busy_o high N+1..N+32, ready_o low, valid_o only in N+33, data_o=0xFFFFFFFD; mul 12345 * 6789 -> 83810205.
REQ-040 During MUL, drive valid_i=1 with a different code and operands every cycle -> none accepted; the multiply result is unchanged.
REQ-041 rst_i pulsed at iteration 10 of a mul -> next cycle IDLE, ready_o=1, data_o=0, no valid_o; a subsequent or 1 | 2 -> 3.
REQ-042 Code 3'b110 -> valid_o in N+1, data_o=0, zero_o=1.
